// File: rtl/grid_coord_queue_pkg.sv
// Shared types and defaults for the grid coordinate queue.
package grid_pkg;

    localparam int COORD_W_DEF   = 4;
    localparam int NUM_CELLS_DEF = 9;

    typedef logic [COORD_W_DEF-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/grid_coord_queue_if.sv
// Coordinate-source / processor-side signal bundle of the grid coordinate queue.
interface grid_coord_queue_if #(
    parameter int COORD_W = 4,
    parameter int DEPTH   = 4
);
    import grid_pkg::*;

    localparam int CNT_W = cnt_width(DEPTH);

    logic               write_en;
    logic [COORD_W-1:0] coord_in;
    logic               int_ack;
    logic               clr_ovf;
    logic               ipu_int;
    logic [COORD_W-1:0] grid_coord;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               overflow;
    logic               bad_coord;

    modport master (
        output write_en, coord_in, int_ack, clr_ovf,
        input  ipu_int, grid_coord, count, full, empty, overflow, bad_coord
    );

    modport slave (
        input  write_en, coord_in, int_ack, clr_ovf,
        output ipu_int, grid_coord, count, full, empty, overflow, bad_coord
    );

endinterface

// File: rtl/grid_coord_fifo.sv
// Coordinate storage: register array, wrapping pointers, occupancy and sticky overflow.
module grid_coord_fifo
    import grid_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int DEPTH   = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_req,
    input  logic [COORD_W-1:0] wr_data,
    input  logic               pop,
    input  logic               overflow_clr,
    output logic [COORD_W-1:0] rd_data,
    output logic [CNT_W-1:0]   count,
    output logic [CNT_W-1:0]   count_next,
    output logic               full,
    output logic               empty,
    output logic               overflow
);

    logic [COORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic               push;
    logic               drop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A full queue still accepts a write when the head leaves on the same edge.
    assign push = wr_req && (!full || pop);
    assign drop = wr_req && full && !pop;

    assign rd_data = empty ? '0 : mem[rptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count_next;
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/grid_coord_queue.sv
// Grid coordinate queue: FIFO of cell coordinates with one interrupt per entry.
// Optional range check of incoming coordinates via GRID_COORD_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | queue empty, no request outstanding
// REQ   | ipu_int high, head presented, waiting for int_ack
// GAP   | one low cycle after an ack so every entry gets its own rising edge
module grid_coord_queue
    import grid_pkg::*;
#(
    parameter int COORD_W   = COORD_W_DEF,
    parameter int DEPTH     = 4,
    parameter int NUM_CELLS = NUM_CELLS_DEF,
    localparam int CNT_W    = cnt_width(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    grid_coord_queue_if.slave  bus
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("grid_coord_queue: DEPTH must be a power of two and at least 2");
    end
    if (NUM_CELLS < 1) begin : g_bad_cells
        $error("grid_coord_queue: NUM_CELLS must be at least 1");
    end

    state_t           state;
    state_t           state_nx;
    logic             ipu_q;
    logic             pop;
    logic             range_ok;
    logic             wr_req;
    logic             bad_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

`ifdef GRID_COORD_RANGE_CHECK_EN
    assign range_ok = ({{(32-COORD_W){1'b0}}, bus.coord_in} < NUM_CELLS);
`else
    assign range_ok = 1'b1;
`endif

    assign wr_req = bus.write_en && range_ok;
    assign pop    = (state == REQ) && bus.int_ack;

    grid_coord_fifo #(
        .COORD_W (COORD_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .wr_data      (bus.coord_in),
        .pop          (pop),
        .overflow_clr (bus.clr_ovf),
        .rd_data      (bus.grid_coord),
        .count        (count),
        .count_next   (count_next),
        .full         (bus.full),
        .empty        (bus.empty),
        .overflow     (bus.overflow)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (count_next != '0) state_nx = REQ;
            REQ:     if (bus.int_ack) state_nx = GAP;
            GAP:     state_nx = (count != '0) ? REQ : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            ipu_q <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            state <= state_nx;
            ipu_q <= (state_nx == REQ);
            bad_q <= bus.write_en && !range_ok;
        end
    end

    assign bus.ipu_int   = ipu_q;
    assign bus.count     = count;
    assign bus.bad_coord = bad_q;

endmodule

// File: tb/tb_grid_coord_queue.sv
// Self-checking bench for grid_coord_queue: queue-level reference model plus directed checks.
module tb_grid_coord_queue;

    localparam int COORD_W   = 4;
    localparam int DEPTH     = 4;
    localparam int NUM_CELLS = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    grid_coord_queue_if #(.COORD_W(COORD_W), .DEPTH(DEPTH)) bus ();

    grid_coord_queue #(
        .COORD_W   (COORD_W),
        .DEPTH     (DEPTH),
        .NUM_CELLS (NUM_CELLS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of coordinates plus "request showing" / "gap cycle" flags.
    logic [COORD_W-1:0] q [$];
    bit m_ipu = 0;
    bit m_gap = 0;
    bit m_ovf = 0;
    bit m_bad = 0;

    always @(posedge clk) begin
        bit in_rng, popped, wr, nipu, ngap;
        int size0;
        if (!rst) begin
            q.delete();
            m_ipu = 0;
            m_gap = 0;
            m_ovf = 0;
            m_bad = 0;
        end else begin
`ifdef GRID_COORD_RANGE_CHECK_EN
            in_rng = (int'(bus.coord_in) < NUM_CELLS);
`else
            in_rng = 1;
`endif
            size0  = q.size();
            popped = m_ipu && bus.int_ack;
            if (popped) void'(q.pop_front());
            wr = bus.write_en && in_rng;
            if (wr && (size0 < DEPTH || popped)) q.push_back(bus.coord_in);
            if (wr && size0 == DEPTH && !popped) m_ovf = 1;
            else if (bus.clr_ovf)                m_ovf = 0;
            m_bad = bus.write_en && !in_rng;
            if (m_ipu) begin
                nipu = !bus.int_ack;
                ngap = bus.int_ack;
            end else if (m_gap) begin
                nipu = (size0 != 0);
                ngap = 0;
            end else begin
                nipu = (q.size() != 0);
                ngap = 0;
            end
            m_ipu = nipu;
            m_gap = ngap;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [COORD_W-1:0] exp_gc;
        exp_gc = (q.size() != 0) ? q[0] : '0;
        chk("m_ipu_int",  32'(bus.ipu_int),    32'(m_ipu));
        chk("m_grid",     32'(bus.grid_coord), 32'(exp_gc));
        chk("m_count",    32'(bus.count),      32'(q.size()));
        chk("m_full",     32'(bus.full),       32'(q.size() == DEPTH));
        chk("m_empty",    32'(bus.empty),      32'(q.size() == 0));
        chk("m_overflow", 32'(bus.overflow),   32'(m_ovf));
        chk("m_bad",      32'(bus.bad_coord),  32'(m_bad));
    end

    task automatic cyc(input logic we, input logic [COORD_W-1:0] c, input logic ack, input logic clr);
        bus.write_en = we;
        bus.coord_in = c;
        bus.int_ack  = ack;
        bus.clr_ovf  = clr;
        @(posedge clk);
        #1;
        bus.write_en = 1'b0;
        bus.coord_in = '0;
        bus.int_ack  = 1'b0;
        bus.clr_ovf  = 1'b0;
    endtask

    task automatic wait_ipu();
        int n = 0;
        while (bus.ipu_int !== 1'b1 && n < 10) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        chk("wait_ipu", 32'(bus.ipu_int), 32'd1);
    endtask

    task automatic drain(input logic [COORD_W-1:0] exp_seq [4], input string name);
        for (int i = 0; i < 4; i++) begin
            wait_ipu();
            chk(name, 32'(bus.grid_coord), 32'(exp_seq[i]));
            cyc(0, 0, 1, 0);
            chk({name, "_gap"}, 32'(bus.ipu_int), 32'd0);
        end
    endtask

    initial begin
        logic [COORD_W-1:0] seq_a [4];
        logic [COORD_W-1:0] seq_b [4];
        bus.write_en = 1'b0;
        bus.coord_in = '0;
        bus.int_ack  = 1'b0;
        bus.clr_ovf  = 1'b0;

        // Reset held with write_en active
        rst = 1'b0;
        cyc(1, 4'd5, 0, 0);
        cyc(1, 4'd5, 0, 0);
        chk("rst_count", 32'(bus.count),   32'd0);
        chk("rst_ipu",   32'(bus.ipu_int), 32'd0);
        chk("rst_empty", 32'(bus.empty),   32'd1);
        chk("rst_grid",  32'(bus.grid_coord), 32'd0);
        rst = 1'b1;

        cyc(1, 4'b0110, 0, 0);
        chk("first_ipu",   32'(bus.ipu_int),    32'd1);
        chk("first_grid",  32'(bus.grid_coord), 32'd6);
        chk("first_count", 32'(bus.count),      32'd1);

        cyc(0, 0, 1, 0);
        chk("ack_gap_ipu", 32'(bus.ipu_int), 32'd0);
        cyc(0, 0, 0, 0);
        chk("ack_idle_ipu",   32'(bus.ipu_int), 32'd0);
        chk("ack_idle_empty", 32'(bus.empty),   32'd1);
        cyc(0, 0, 1, 0);
        chk("idle_ack_count", 32'(bus.count),   32'd0);
        chk("idle_ack_ipu",   32'(bus.ipu_int), 32'd0);

        // Burst of four
        cyc(1, 4'd1, 0, 0);
        cyc(1, 4'd2, 0, 0);
        cyc(1, 4'd3, 0, 0);
        cyc(1, 4'd4, 0, 0);
        chk("burst_full",  32'(bus.full),  32'd1);
        chk("burst_count", 32'(bus.count), 32'd4);
        seq_a = '{4'd1, 4'd2, 4'd3, 4'd4};
        drain(seq_a, "burst_seq");

        // Overflow, clear, and write-while-full with same-edge ack
        cyc(1, 4'd1, 0, 0);
        cyc(1, 4'd2, 0, 0);
        cyc(1, 4'd3, 0, 0);
        cyc(1, 4'd5, 0, 0);
        cyc(1, 4'd7, 0, 0);
        chk("ovf_set",   32'(bus.overflow), 32'd1);
        chk("ovf_count", 32'(bus.count),    32'd4);
        cyc(0, 0, 0, 1);
        chk("ovf_clr",   32'(bus.overflow), 32'd0);
        cyc(1, 4'd8, 1, 0);
        chk("full_ack_count", 32'(bus.count),    32'd4);
        chk("full_ack_ovf",   32'(bus.overflow), 32'd0);
        seq_b = '{4'd2, 4'd3, 4'd5, 4'd8};
        drain(seq_b, "ovf_seq");

        // Push and ack together with a single entry
        cyc(1, 4'd3, 0, 0);
        wait_ipu();
        cyc(1, 4'd4, 1, 0);
        chk("pa_count", 32'(bus.count),   32'd1);
        chk("pa_gap",   32'(bus.ipu_int), 32'd0);
        cyc(0, 0, 0, 0);
        chk("pa_req",   32'(bus.ipu_int),    32'd1);
        chk("pa_grid",  32'(bus.grid_coord), 32'd4);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);

        // Pointer wrap
        for (int i = 0; i < 10; i++) begin
            logic [COORD_W-1:0] v;
            v = COORD_W'((i % 8) + 1);
            cyc(1, v, 0, 0);
            wait_ipu();
            chk("wrap_grid", 32'(bus.grid_coord), 32'(v));
            cyc(0, 0, 1, 0);
        end
        cyc(0, 0, 0, 0);

        // Reset mid-burst
        cyc(1, 4'd1, 0, 0);
        cyc(1, 4'd2, 0, 0);
        cyc(1, 4'd3, 0, 0);
        chk("mid_count3", 32'(bus.count), 32'd3);
        rst = 1'b0;
        cyc(0, 0, 0, 0);
        rst = 1'b1;
        chk("mid_rst_count", 32'(bus.count),   32'd0);
        chk("mid_rst_ipu",   32'(bus.ipu_int), 32'd0);
        cyc(0, 0, 0, 0);

`ifdef GRID_COORD_RANGE_CHECK_EN
        cyc(1, 4'd9, 0, 0);
        chk("rc_bad",   32'(bus.bad_coord), 32'd1);
        chk("rc_count", 32'(bus.count),     32'd0);
        cyc(0, 0, 0, 0);
        chk("rc_bad_once", 32'(bus.bad_coord), 32'd0);
        cyc(1, 4'd8, 0, 0);
        chk("rc_ok_count", 32'(bus.count),     32'd1);
        chk("rc_ok_bad",   32'(bus.bad_coord), 32'd0);
`else
        cyc(1, 4'd9, 0, 0);
        chk("nrc_bad",   32'(bus.bad_coord),  32'd0);
        chk("nrc_count", 32'(bus.count),      32'd1);
        chk("nrc_grid",  32'(bus.grid_coord), 32'd9);
`endif
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/grid_coord_queue.md
Name: grid_coord_queue

Overview:
- Parametrised successor to the single-entry grid coordinate register.
- Buffers up to DEPTH grid-cell coordinates from the input/IPU side in a FIFO.
- Presents the oldest coordinate to the processor and raises an interrupt (ipu_int) for each entry.
- The processor retires each entry with a one-cycle int_ack pulse. The block sits between the coordinate source and proc's grid_coord/ipu_int/int_ack pins.

Parameters:
- COORD_W, 4, width of one coordinate.
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- NUM_CELLS, 9, number of legal cells; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets).
- write_en  in  1  push coord_in this cycle.
- coord_in  in  COORD_W  coordinate to push.
- int_ack  in  1  processor acknowledge; one-cycle pulse pops the head.
- clr_ovf  in  1  clears the sticky overflow flag.
- ipu_int  out  1  interrupt request; registered.
- grid_coord  out  COORD_W  head entry; valid while ipu_int==1.
- count  out  $clog2(DEPTH+1)  occupancy.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow  out  1  sticky; a write was dropped.
- bad_coord  out  1  one-cycle pulse; a write was rejected for range (optional feature).

Behaviour:
- Reset values: ipu_int=0, count=0, empty=1, full=0, overflow=0, bad_coord=0, FSM=IDLE, read/write pointers=0. grid_coord=0 while empty.
- Reset asserted mid-operation discards all entries and any pending request on that edge.
- Storage: DEPTH×COORD_W register array; read and write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; separate count register.
- Push: occurs when write_en=1 and the entry is accepted. An entry is accepted if not full, or if full and a pop occurs on the same edge. Stores coord_in at wptr; wptr+1.
- Overflow: write_en=1 while full with no same-edge pop drops the data and sets overflow=1.
- Overflow clear: clr_ovf=1 clears overflow. If a drop and clr_ovf=1 coincide, the set wins.
- Pop: occurs only on int_ack=1 in state REQ. rptr+1.
- Ignored acknowledge: int_ack in IDLE or GAP is ignored; no pop, no error.
- count next value = count + push − pop. Simultaneous push and pop leave count unchanged.
- grid_coord = mem[rptr], combinational from the registers.
- FSM (ipu_int=1 only in REQ):
  - IDLE: if count_next≠0 → REQ. A write into an empty queue at edge N therefore shows ipu_int=1 and a valid grid_coord immediately after edge N.
  - REQ: hold ipu_int=1 and a stable grid_coord until int_ack; on int_ack → GAP.
  - GAP: ipu_int=0 for exactly one cycle. Then → REQ if count≠0, else → IDLE. This guarantees a fresh rising edge per entry.
- Boundary: push and ack on the same edge with count==1 gives count stays 1 → GAP → REQ with the new head.
- Boundary: with DEPTH entries buffered, DEPTH acks each spaced by GAP produce DEPTH distinct ipu_int pulses.

Optional Feature:
- Macro: GRID_COORD_RANGE_CHECK_EN.
- Defined: a write with coord_in ≥ NUM_CELLS is not stored. It pulses bad_coord=1 for the cycle after it is sampled and does not affect overflow or count.
- Not defined: all coordinates are stored; bad_coord is tied to 0 and NUM_CELLS is unused.

Decomposition:
- Package grid_pkg:
  - FSM state enum (IDLE, REQ, GAP).
  - Default COORD_W and NUM_CELLS constants.
  - Typedef coord_t.
- Natural sub-module: grid_coord_fifo, holding storage, pointers, count, full/empty and overflow.
- The top level holds the FSM, the pop qualification and the range check.

Test Plan:
- Reset: hold rst=0 for 2 edges with write_en=1 → count=0, ipu_int=0, empty=1. Release, write 4'b0110 → after that edge ipu_int=1, grid_coord=6, count=1.
- Ack: pulse int_ack for 1 cycle → next cycle ipu_int=0 (GAP), then IDLE, empty=1. A second int_ack in IDLE → no change.
- Burst: write 1,2,3,4 back-to-back, then ack each as ipu_int rises → grid_coord sequence 1,2,3,4. ipu_int is low exactly 1 cycle between requests; full=1 after the 4th write.
- Overflow: at full, write 7 → overflow=1, count=4, 7 never appears. Pulse clr_ovf → overflow=0. At full, write 8 together with int_ack → stored, count stays 4, no overflow.
- Wrap: perform 10 push/pop pairs with DEPTH=4 → ordering preserved across pointer wrap. Reset mid-burst with count=3 → count=0, ipu_int=0 next cycle.
- With GRID_COORD_RANGE_CHECK_EN: write 9 → bad_coord pulses once, count unchanged. Write 8 → accepted.
